// File: rtl/dual_port_mem_clr_if.sv
// Port bundle for dual_port_mem_clr: two independent address/data ports plus READY.
// Handshake: the ports are accepted only while READY=1. A cycle with CEx=1 is a
// read, and also a masked write when WEx=1. Qx is valid after the module's read latency.
interface dual_port_mem_clr_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    logic [ADDR_WIDTH-1:0] A0, A1;
    logic [DATA_WIDTH-1:0] D0, D1;
    logic [DATA_WIDTH-1:0] WEM0, WEM1;
    logic [DATA_WIDTH-1:0] Q0, Q1;
    logic                  WE0, WE1;
    logic                  CE0, CE1;
    logic                  READY;

    modport master (
        output A0, D0, WEM0, WE0, CE0,
        output A1, D1, WEM1, WE1, CE1,
        input  Q0, Q1, READY
    );

    modport slave (
        input  A0, D0, WEM0, WE0, CE0,
        input  A1, D1, WEM1, WE1, CE1,
        output Q0, Q1, READY
    );
endinterface

// File: rtl/dual_port_mem_clr.sv
// True-dual-port memory with per-bit write masks and an optional output register.
// After reset, a clear engine writes INIT_VALUE to every word before the ports open.
module dual_port_mem_clr #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    dual_port_mem_clr_if.slave    bus,
    output logic                  dbg_state_o
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  clr_we;
    logic                  run;
    logic                  rd0, rd1, wr0, wr1;
    logic [DATA_WIDTH-1:0] new0, base1, new1;
    logic [DATA_WIDTH-1:0] s1_0_q, s1_1_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == LAST_ADDR) state_d = ST_RUN;
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    assign run         = (state_q == ST_RUN);
    assign bus.READY   = run;
    assign dbg_state_o = state_q;

    assign rd0 = run && bus.CE0;
    assign rd1 = run && bus.CE1;
    assign wr0 = rd0 && bus.WE0;
    assign wr1 = rd1 && bus.WE1;

    // Port 1 merges on top of port 0's result when both hit one word, so it wins shared bits.
    assign new0  = (mem[bus.A0] & ~bus.WEM0) | (bus.D0 & bus.WEM0);
    assign base1 = (wr0 && (bus.A0 == bus.A1)) ? new0 : mem[bus.A1];
    assign new1  = (base1 & ~bus.WEM1) | (bus.D1 & bus.WEM1);

    always_ff @(posedge CLK) begin
        if (RSTN) begin
            if (clr_we) begin
                mem[cnt_q[ADDR_WIDTH-1:0]] <= INIT_VALUE;
            end else begin
                if (wr0) mem[bus.A0] <= new0;
                if (wr1) mem[bus.A1] <= new1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            s1_0_q <= '0;
            s1_1_q <= '0;
        end else begin
            if (rd0) s1_0_q <= mem[bus.A0];
            if (rd1) s1_1_q <= mem[bus.A1];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic                  ce0_q, ce1_q;
            logic [DATA_WIDTH-1:0] s2_0_q, s2_1_q;
            always_ff @(posedge CLK) begin
                if (!RSTN) begin
                    ce0_q  <= 1'b0;
                    ce1_q  <= 1'b0;
                    s2_0_q <= '0;
                    s2_1_q <= '0;
                end else begin
                    ce0_q <= rd0;
                    ce1_q <= rd1;
                    if (ce0_q) s2_0_q <= s1_0_q;
                    if (ce1_q) s2_1_q <= s1_1_q;
                end
            end
            assign bus.Q0 = s2_0_q;
            assign bus.Q1 = s2_1_q;
        end else begin : g_noreg
            assign bus.Q0 = s1_0_q;
            assign bus.Q1 = s1_1_q;
        end
    endgenerate
endmodule
